seg_scan_capture: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the com/seg/dot lines as they leave the chip, decodes each digit's segment pattern back to BCD, and assembles the six digits (HH:MM:SS) into one 24-bit time word.
- Used for on-board self-check, where time_out is compared against the time register, and as a verification monitor in system benches.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 35 +++
 rtl/seg_scan_capture.sv | 182 ++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan capture path: segment patterns,
// special nibble codes, digit slot indices and the capture FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] NIB_BLANK = 4'hB;
    localparam logic [3:0] NIB_ERR   = 4'hF;

    // Slot index equals the com bit that enables the digit.
    localparam int DIG_H10 = 0;
    localparam int DIG_H1  = 1;
    localparam int DIG_M10 = 2;
    localparam int DIG_M1  = 3;
    localparam int DIG_S10 = 4;
    localparam int DIG_S1  = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder; blank and undecodable patterns
// are flagged and mapped to their dedicated nibble codes.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = NIB_ERR;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: begin
                nibble = NIB_BLANK;
                blank  = 1'b1;
            end
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples the multiplexed display lines and rebuilds the HH:MM:SS BCD word.
// Optional macro SEG_SCAN_DOT_CAPTURE_EN adds per-digit decimal point capture (dots_out).
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  com,
    input  logic [6:0]  seg,
    input  logic        dot,
    output logic [23:0] time_out,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        seg_err,
    output logic        blank_seen,
    output logic        stale
`ifdef SEG_SCAN_DOT_CAPTURE_EN
    ,
    output logic [5:0]  dots_out
`endif
);

    scan_state_t state, state_n;
    logic [14:0] rec, rec_n, sample;
    logic [15:0] cnt, cnt_n;
    logic        capture, legal, complete;
    logic [5:0]  sel, seen;
    logic [3:0]  dec_nib;
    logic        dec_blank, dec_err;
    logic [3:0]  slot_val [6];
    logic [23:0] slot_word;
    logic        pend_err, pend_blank;
    logic [31:0] tcnt;

    assign sample   = {com, seg};
    assign sel      = ~com[5:0];
    assign legal    = (com[7:6] == 2'b11) && $onehot(sel);
    assign complete = &seen;

    seg7_decode u_dec (
        .seg    (seg),
        .nibble (dec_nib),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rec   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            rec   <= rec_n;
            cnt   <= cnt_n;
        end
    end

    // A dwell is captured once, on the sample that brings the run to SETTLE.
    always_comb begin
        state_n = state;
        rec_n   = rec;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    rec_n = sample;
                    cnt_n = 16'd1;
                    if (SETTLE <= 1) begin
                        capture = 1'b1;
                        state_n = HELD;
                    end else begin
                        state_n = SETTLING;
                    end
                end
            end
            SETTLING: begin
                if (!legal) begin
                    state_n = IDLE;
                end else if (sample == rec) begin
                    cnt_n = cnt + 16'd1;
                    if (cnt_n >= 16'(SETTLE)) begin
                        capture = 1'b1;
                        state_n = HELD;
                    end
                end else begin
                    rec_n = sample;
                    cnt_n = 16'd1;
                end
            end
            HELD: begin
                if (sample != rec) begin
                    if (legal) begin
                        rec_n   = sample;
                        cnt_n   = 16'd1;
                        state_n = SETTLING;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        slot_word = {slot_val[DIG_H10], slot_val[DIG_H1], slot_val[DIG_M10],
                     slot_val[DIG_M1], slot_val[DIG_S10], slot_val[DIG_S1]};
    end

    // A capture landing on the completion cycle seeds the next frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) slot_val[i] <= '0;
            seen          <= '0;
            pend_err      <= 1'b0;
            pend_blank    <= 1'b0;
            time_out      <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            seg_err       <= 1'b0;
            blank_seen    <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (capture && sel[i]) slot_val[i] <= dec_nib;
            end
            if (complete) begin
                time_out      <= slot_word;
                frame_valid   <= 1'b1;
                frame_changed <= (slot_word != time_out);
                seg_err       <= pend_err;
                blank_seen    <= pend_blank;
                seen          <= capture ? sel : 6'b0;
                pend_err      <= capture && dec_err;
                pend_blank    <= capture && dec_blank;
            end else if (capture) begin
                seen       <= seen | sel;
                pend_err   <= pend_err | dec_err;
                pend_blank <= pend_blank | dec_blank;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt  <= '0;
            stale <= 1'b1;
        end else if (complete) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (tcnt != 32'(TIMEOUT - 1)) begin
            tcnt <= tcnt + 32'd1;
            if (tcnt == 32'(TIMEOUT - 2)) stale <= 1'b1;
        end
    end

`ifdef SEG_SCAN_DOT_CAPTURE_EN
    logic [5:0] slot_dot;

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_dot <= '0;
            dots_out <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (capture && sel[i]) slot_dot[i] <= dot;
            end
            if (complete) dots_out <= slot_dot;
        end
    end
`else
    logic unused_dot;
    assign unused_dot = dot;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture (SETTLE=4, TIMEOUT=100).
module tb_seg_scan_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  com;
    logic [6:0]  seg;
    logic        dot;
    logic [23:0] time_out;
    logic        frame_valid, frame_changed, seg_err, blank_seen, stale;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    int base;
    logic last_changed = 1'b0;
    logic last_stale   = 1'b1;

    seg_scan_capture #(.SETTLE(4), .TIMEOUT(100)) dut (
        .clock         (clock),
        .reset         (reset),
        .com           (com),
        .seg           (seg),
        .dot           (dot),
        .time_out      (time_out),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .seg_err       (seg_err),
        .blank_seen    (blank_seen),
        .stale         (stale)
    );

    always #5 clock = ~clock;

    // Records every frame_valid pulse and the flags seen alongside it.
    always @(negedge clock) begin
        if (frame_valid === 1'b1) begin
            fv_count++;
            last_changed = frame_changed;
            last_stale   = stale;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_digit(input int idx, input logic [6:0] pattern, input int cycles);
        logic [7:0] c;
        c = 8'hFF;
        c[idx] = 1'b0;
        @(negedge clock);
        com = c;
        seg = pattern;
        repeat (cycles - 1) @(negedge clock);
    endtask

    task automatic apply_idle(input int cycles);
        @(negedge clock);
        com = 8'hFF;
        seg = 7'h00;
        repeat (cycles - 1) @(negedge clock);
    endtask

    task automatic apply_frame(input logic [6:0] p0, p1, p2, p3, p4, p5);
        apply_digit(0, p0, 10);
        apply_digit(1, p1, 10);
        apply_digit(2, p2, 10);
        apply_digit(3, p3, 10);
        apply_digit(4, p4, 10);
        apply_digit(5, p5, 10);
        apply_idle(3);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        com   = 8'hFF;
        seg   = 7'h00;
        dot   = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_output("reset_time", time_out, 24'h0);
        check_output("reset_fv", frame_valid, 1'b0);
        check_output("reset_fc", frame_changed, 1'b0);
        check_output("reset_err", seg_err, 1'b0);
        check_output("reset_blank", blank_seen, 1'b0);
        check_output("reset_stale", stale, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        apply_frame(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F);
        check_output("clean_fv_count", fv_count, 1);
        check_output("clean_time", time_out, 24'h123456);
        check_output("clean_changed", last_changed, 1'b1);
        check_output("clean_err", seg_err, 1'b0);
        check_output("clean_blank", blank_seen, 1'b0);
        check_output("clean_stale", stale, 1'b0);

        apply_frame(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F);
        check_output("repeat_fv_count", fv_count, 2);
        check_output("repeat_changed", last_changed, 1'b0);
        check_output("repeat_time", time_out, 24'h123456);

        apply_digit(0, 7'h5F, 10);
        apply_digit(1, 7'h5B, 10);
        apply_digit(2, 7'h33, 10);
        apply_digit(3, 7'h79, 10);
        apply_digit(4, 7'h6D, 10);
        apply_digit(5, 7'h7F, 3);
        apply_idle(6);
        #1;
        check_output("glitch_no_frame", fv_count, 2);
        check_output("glitch_time_held", time_out, 24'h123456);
        apply_digit(5, 7'h30, 10);
        apply_idle(3);
        #1;
        check_output("glitch_fv_count", fv_count, 3);
        check_output("glitch_time", time_out, 24'h654321);
        check_output("glitch_changed", last_changed, 1'b1);

        apply_frame(7'h30, 7'h6D, 7'h79, 7'h01, 7'h5B, 7'h5F);
        check_output("err_time", time_out, 24'h123F56);
        check_output("err_flag", seg_err, 1'b1);
        check_output("err_blank", blank_seen, 1'b0);

        apply_frame(7'h00, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F);
        check_output("blank_time", time_out, 24'hB23456);
        check_output("blank_flag", blank_seen, 1'b1);
        check_output("blank_err", seg_err, 1'b0);

        base = fv_count;
        apply_digit(0, 7'h7E, 10);
        apply_digit(1, 7'h7E, 10);
        apply_digit(2, 7'h7E, 10);
        apply_digit(3, 7'h7E, 10);
        @(negedge clock);
        reset = 1'b1;
        com   = 8'hFF;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("midreset_time", time_out, 24'h0);
        check_output("midreset_stale", stale, 1'b1);
        apply_frame(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F);
        check_output("midreset_frames", fv_count - base, 1);
        check_output("midreset_time2", time_out, 24'h123456);
        check_output("midreset_changed", last_changed, 1'b1);
        check_output("midreset_stale_at_fv", last_stale, 1'b0);

        apply_idle(80);
        #1;
        check_output("timeout_not_yet", stale, 1'b0);
        apply_idle(30);
        #1;
        check_output("timeout_stale", stale, 1'b1);
        apply_frame(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h60);
        check_output("timeout_err_time", time_out, 24'h12345F);
        check_output("timeout_stale_at_fv", last_stale, 1'b0);
        check_output("timeout_stale_after", stale, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
